// File: rtl/polaris_pkg.sv
// Shared encodings for the Polaris instruction-fetch path: request sizes,
// the illegal-instruction word and the fetch bridge state encoding.
package polaris_pkg;

  typedef logic [1:0] isiz_t;
  typedef logic [1:0] ifb_state_t;

  localparam isiz_t ISIZ_NONE = 2'b00;
  localparam isiz_t ISIZ_H    = 2'b01;
  localparam isiz_t ISIZ_W    = 2'b10;
  localparam isiz_t ISIZ_D    = 2'b11;

  localparam logic [31:0] ILLEGAL_INSN = 32'h0000_0000;

  localparam ifb_state_t ST_IDLE = 2'd0;
  localparam ifb_state_t ST_LO   = 2'd1;
  localparam ifb_state_t ST_HI   = 2'd2;
  localparam ifb_state_t ST_ACK  = 2'd3;

  // Bits needed to hold a timeout limit of t cycles.
  function automatic int timer_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/ifb_timer.sv
// Per-transfer watchdog for the fetch bridge: a loadable down-counter whose
// expiry flag marks the last permitted wait cycle of a bus transfer.
module ifb_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  // A count of one is the final cycle; a cleared counter (zero) never expires.
  assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/polaris_ifetch_bridge.sv
// CPU instruction-fetch port to 16-bit program-memory bridge: one or two
// half-word reads assembled little-endian, with a bounded per-transfer timeout.
module polaris_ifetch_bridge
  import polaris_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [63:0]       iadr_i,
  input  logic [1:0]        isiz_i,
  output logic              iack_o,
  output logic [31:0]       idat_o,
  output logic              mcyc_o,
  output logic [ADDR_W-1:0] madr_o,
  input  logic              mack_i,
  input  logic [15:0]       mdat_i,
  output logic              timeout_o
);

  localparam int             TW    = timer_width(TIMEOUT);
  localparam logic [TW-1:0]  TLOAD = TW'(TIMEOUT);

  ifb_state_t state_q;
  logic       half_q;

  logic req_go;
  logic tmr_load;
  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  // Upper address bits wrap away and bit 0 is never used for addressing.
  logic unused_iadr;
  assign unused_iadr = ^{iadr_i[63:ADDR_W], iadr_i[0]};

  // NOTE: every always_comb output gets a value on every path (here with no
  // branches at all), which is what keeps synthesis from inferring latches.
  always_comb begin
    req_go    = (state_q == ST_IDLE) && ((isiz_i == ISIZ_W) || (isiz_i == ISIZ_H));
    tmr_load  = req_go || ((state_q == ST_LO) && mack_i);
    tmr_en    = (state_q == ST_LO) || (state_q == ST_HI);
    tmr_clear = !tmr_en;
  end

  ifb_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (TLOAD),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      half_q    <= 1'b0;
      iack_o    <= 1'b0;
      idat_o    <= ILLEGAL_INSN;
      mcyc_o    <= 1'b0;
      madr_o    <= '0;
      timeout_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          iack_o    <= 1'b0;
          timeout_o <= 1'b0;
          if (isiz_i == ISIZ_W) begin
            state_q <= ST_LO;
            half_q  <= 1'b0;
            mcyc_o  <= 1'b1;
            madr_o  <= {iadr_i[ADDR_W-1:2], 2'b00};
          end else if (isiz_i == ISIZ_H) begin
            state_q <= ST_HI;
            half_q  <= 1'b1;
            mcyc_o  <= 1'b1;
            madr_o  <= {iadr_i[ADDR_W-1:1], 1'b0};
          end else if (isiz_i == ISIZ_D) begin
            // Double fetches are unsupported: answer at once with an illegal word.
            state_q <= ST_ACK;
            idat_o  <= ILLEGAL_INSN;
            iack_o  <= 1'b1;
          end
        end

        ST_LO: begin
          if (mack_i) begin
            idat_o[15:0] <= mdat_i;
            madr_o       <= madr_o + ADDR_W'(2);
            state_q      <= ST_HI;
          end else if (tmr_expired) begin
            state_q   <= ST_ACK;
            mcyc_o    <= 1'b0;
            idat_o    <= ILLEGAL_INSN;
            iack_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
        end

        ST_HI: begin
          if (mack_i) begin
            if (half_q) begin
              idat_o <= {16'h0000, mdat_i};
            end else begin
              idat_o[31:16] <= mdat_i;
            end
            state_q <= ST_ACK;
            mcyc_o  <= 1'b0;
            iack_o  <= 1'b1;
          end else if (tmr_expired) begin
            state_q   <= ST_ACK;
            mcyc_o    <= 1'b0;
            idat_o    <= ILLEGAL_INSN;
            iack_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
        end

        ST_ACK: begin
          // Unconditional return; a request still held here is seen fresh in IDLE.
          state_q   <= ST_IDLE;
          iack_o    <= 1'b0;
          timeout_o <= 1'b0;
          mcyc_o    <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          iack_o  <= 1'b0;
          mcyc_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
